// File: rtl/ay_tone_noise.sv
// AY tone/noise generator: holds R0-R7, derives tone steps from the AY clock
// and produces three mixed 1-bit channels plus the LFSR noise bit.
module ay_tone_noise #(
    parameter int unsigned PRESCALE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ay_clk,
    input  logic       wr,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       chan_a,
    output logic       chan_b,
    output logic       chan_c,
    output logic       noise
);

    localparam int unsigned PW = $clog2(PRESCALE);

    logic          ay_d;
    logic          tick;
    logic          step;
    logic [PW-1:0] pcnt;

    logic [7:0]    fine   [3];
    logic [3:0]    coarse [3];
    logic [4:0]    np;
    logic [7:0]    mix;

    logic [11:0]   tc      [3];
    logic [11:0]   tp_eff  [3];
    logic [2:0]    tone;
    logic [2:0]    tone_wrap;

    logic          half;
    logic [4:0]    ncnt;
    logic [4:0]    np_eff;
    logic          nwrap;
    logic [16:0]   lfsr;

    assign tick  = ay_clk & ~ay_d;
    assign step  = tick && (pcnt == PW'(PRESCALE - 1));
    assign noise = lfsr[0];

    // ay_d resets high so a level already high at release is not taken as an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ay_d <= 1'b1;
            pcnt <= '0;
        end else begin
            ay_d <= ay_clk;
            if (tick)
                pcnt <= pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                fine[i]   <= '0;
                coarse[i] <= '0;
            end
            np  <= '0;
            mix <= '0;
        end else if (wr) begin
            case (addr)
                4'd0: fine[0]   <= wdata;
                4'd1: coarse[0] <= wdata[3:0];
                4'd2: fine[1]   <= wdata;
                4'd3: coarse[1] <= wdata[3:0];
                4'd4: fine[2]   <= wdata;
                4'd5: coarse[2] <= wdata[3:0];
                4'd6: np        <= wdata[4:0];
                4'd7: mix       <= wdata;
                default: ;
            endcase
        end
    end

    // Wide compare so a count left above a newly shortened period wraps at once
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            tp_eff[i]    = ({coarse[i], fine[i]} == 12'd0) ? 12'd1 : {coarse[i], fine[i]};
            tone_wrap[i] = ({1'b0, tc[i]} + 13'd1) >= {1'b0, tp_eff[i]};
        end
        np_eff = (np == 5'd0) ? 5'd1 : np;
        nwrap  = ({1'b0, ncnt} + 6'd1) >= {1'b0, np_eff};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++)
                tc[i] <= '0;
            tone <= '0;
        end else if (step) begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (tone_wrap[i]) begin
                    tc[i]   <= '0;
                    tone[i] <= ~tone[i];
                end else begin
                    tc[i] <= tc[i] + 12'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half <= 1'b0;
            ncnt <= '0;
            lfsr <= 17'h00001;
        end else if (step) begin
            half <= ~half;
            if (half) begin
                if (nwrap) begin
                    ncnt <= '0;
                    lfsr <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
                end else begin
                    ncnt <= ncnt + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_a <= 1'b0;
            chan_b <= 1'b0;
            chan_c <= 1'b0;
            rdata  <= '0;
        end else begin
            chan_a <= (tone[0] | mix[0]) & (lfsr[0] | mix[3]);
            chan_b <= (tone[1] | mix[1]) & (lfsr[0] | mix[4]);
            chan_c <= (tone[2] | mix[2]) & (lfsr[0] | mix[5]);
            case (addr)
                4'd0: rdata <= fine[0];
                4'd1: rdata <= {4'h0, coarse[0]};
                4'd2: rdata <= fine[1];
                4'd3: rdata <= {4'h0, coarse[1]};
                4'd4: rdata <= fine[2];
                4'd5: rdata <= {4'h0, coarse[2]};
                4'd6: rdata <= {3'b000, np};
                4'd7: rdata <= mix;
                default: rdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ay_tone_noise.sv
// Self-checking bench for ay_tone_noise: directed scenarios plus randomized
// register settings checked against closed-form step-count predictions.
module tb_ay_tone_noise;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ay_clk = 1'b0;
    logic       wr     = 1'b0;
    logic [3:0] addr   = 4'd0;
    logic [7:0] wdata  = 8'd0;
    logic [7:0] rdata;
    logic       chan_a, chan_b, chan_c, noise;
    logic [2:0] ch;
    logic [2:0] early;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    ay_tone_noise #(.PRESCALE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ay_clk(ay_clk),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .chan_a(chan_a),
        .chan_b(chan_b),
        .chan_c(chan_c),
        .noise (noise)
    );

    assign ch = {chan_c, chan_b, chan_a};

    always #5 clk = ~clk;

    function automatic logic [16:0] lfsr_after(input int unsigned k);
        logic [16:0] l;
        l = 17'h00001;
        for (int unsigned j = 0; j < k; j++)
            l = {l[0] ^ l[3], l[16:1]};
        return l;
    endfunction

    // Tone from reset toggles once per effective period of steps
    function automatic logic tone_after(input int unsigned n, input int unsigned tp);
        int unsigned tpe;
        tpe = (tp == 0) ? 1 : tp;
        return ((n / tpe) % 2) == 1;
    endfunction

    // Noise counter advances every second step; the LFSR shifts once per period
    function automatic logic noise_after(input int unsigned n, input int unsigned np);
        int unsigned npe;
        logic [16:0] l;
        npe = (np == 0) ? 1 : np;
        l = lfsr_after((n / 2) / npe);
        return l[0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic level);
        @(negedge clk);
        rst_n = 1'b0; ay_clk = level; wr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
        @(negedge clk);
        addr = a;
        repeat (2) @(negedge clk);
        check(tag, {24'd0, rdata}, {24'd0, exp});
    endtask

    // One AY clock period (8 clk high, 8 clk low), optionally with a write on the rising edge
    task automatic ay_edge(input logic do_wr, input logic [3:0] a, input logic [7:0] d);
        ay_clk = 1'b1;
        if (do_wr) begin
            wr = 1'b1; addr = a; wdata = d;
        end
        @(negedge clk);
        wr = 1'b0;
        early = ch;
        repeat (7) @(negedge clk);
        ay_clk = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic step_run(input int unsigned n);
        repeat (n * 8) ay_edge(1'b0, 4'd0, 8'd0);
    endtask

    initial begin
        int unsigned tp [3];
        int unsigned npv, n;
        logic [7:0]  mx;
        logic [7:0]  exp_reg [8];
        logic        e;

        // Noise on channel A only, one LFSR shift every second step
        do_reset(1'b0);
        wr_reg(4'd6, 8'd1);
        wr_reg(4'd7, 8'h37);
        for (int unsigned s = 1; s <= 32; s++) begin
            step_run(1);
            check("noise_chan_a", {31'd0, chan_a}, {31'd0, noise_after(s, 1)});
            check("noise_bit", {31'd0, noise}, {31'd0, noise_after(s, 1)});
        end

        // Mid-operation reset with ay_clk high
        @(negedge clk);
        rst_n = 1'b0; ay_clk = 1'b1;
        #1;
        check("rst_chan", {29'd0, ch}, 32'd0);
        check("rst_noise", {31'd0, noise}, 32'd1);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wr_reg(4'd0, 8'd1);
        wr_reg(4'd1, 8'd0);
        wr_reg(4'd7, 8'h3E);
        @(negedge clk);
        ay_clk = 1'b0;
        repeat (8) @(negedge clk);
        repeat (7) ay_edge(1'b0, 4'd0, 8'd0);
        check("no_tick_at_release", {31'd0, chan_a}, 32'd0);
        ay_edge(1'b0, 4'd0, 8'd0);
        check("first_step", {31'd0, chan_a}, 32'd1);

        // Tone A periods 1, 0 and 3
        step_run(1);
        check("chan_lat_early", {31'd0, early[0]}, 32'd1);
        check("tp1_toggle", {31'd0, chan_a}, 32'd0);
        wr_reg(4'd0, 8'd0);
        step_run(1);
        check("tp0_toggle", {31'd0, chan_a}, 32'd1);
        wr_reg(4'd0, 8'd3);
        step_run(2);
        check("tp3_hold", {31'd0, chan_a}, 32'd1);
        step_run(1);
        check("tp3_toggle", {31'd0, chan_a}, 32'd0);

        // Mixer write reaches chan_a two clk after the write edge
        @(negedge clk);
        addr = 4'd7; wdata = 8'h3F; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        check("mix_lat_early", {31'd0, chan_a}, 32'd0);
        @(negedge clk);
        check("mix_lat", {31'd0, chan_a}, 32'd1);

        // Coarse masking and read latency
        @(negedge clk);
        addr = 4'd1; wdata = 8'hF2; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        check("rd_lat_early", {24'd0, rdata}, 32'd0);
        @(negedge clk);
        check("coarse_mask", {24'd0, rdata}, 32'h02);

        // Period shortened below the current count
        do_reset(1'b0);
        wr_reg(4'd0, 8'd200);
        wr_reg(4'd7, 8'h3E);
        step_run(100);
        check("tp200_hold", {31'd0, chan_a}, 32'd0);
        wr_reg(4'd0, 8'd50);
        step_run(1);
        check("shrink_wrap", {31'd0, chan_a}, 32'd1);
        step_run(49);
        check("tp50_hold", {31'd0, chan_a}, 32'd1);
        step_run(1);
        check("tp50_toggle", {31'd0, chan_a}, 32'd0);

        // Write landing in the step cycle uses the old period
        do_reset(1'b0);
        wr_reg(4'd0, 8'd2);
        wr_reg(4'd7, 8'h3E);
        step_run(1);
        check("coll_pre", {31'd0, chan_a}, 32'd0);
        repeat (7) ay_edge(1'b0, 4'd0, 8'd0);
        ay_edge(1'b1, 4'd0, 8'd5);
        check("coll_old_period", {31'd0, chan_a}, 32'd1);
        step_run(4);
        check("coll_new_hold", {31'd0, chan_a}, 32'd1);
        step_run(1);
        check("coll_new_toggle", {31'd0, chan_a}, 32'd0);

        // Randomized periods, noise period and mixer
        for (int t = 0; t < 5; t++) begin
            do_reset(1'b0);
            for (int unsigned i = 0; i < 3; i++) begin
                tp[i] = $urandom_range(0, 5);
                wr_reg(4'(2 * i), 8'(tp[i]));
                wr_reg(4'(2 * i + 1), {4'($urandom), 4'h0});
                exp_reg[2 * i]     = 8'(tp[i]);
                exp_reg[2 * i + 1] = 8'h00;
            end
            npv = $urandom_range(0, 3);
            wr_reg(4'd6, {3'($urandom), 5'(npv)});
            exp_reg[6] = 8'(npv);
            mx = 8'($urandom);
            wr_reg(4'd7, mx);
            exp_reg[7] = mx;
            wr_reg(4'($urandom_range(8, 15)), 8'($urandom));
            n = $urandom_range(4, 20);
            step_run(n);
            for (int unsigned i = 0; i < 3; i++) begin
                e = (tone_after(n, tp[i]) | mx[i]) & (noise_after(n, npv) | mx[i + 3]);
                check("rand_chan", {31'd0, ch[i]}, {31'd0, e});
            end
            check("rand_noise", {31'd0, noise}, {31'd0, noise_after(n, npv)});
            for (int unsigned a = 0; a < 8; a++)
                rd_check("rand_read", 4'(a), exp_reg[a]);
            rd_check("read_high_addr", 4'($urandom_range(8, 15)), 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
